// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. An accepted start captures operands a and b into shift
// registers; one bit is then processed per clock, LSB first, through a single
// full adder and a carry flop. After WIDTH processing cycles the result is
// presented on sum/cout and done pulses for one cycle.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   Adds input port sub. When sub=1 is captured with start, the module
//   computes a-b by inverting b and presetting the carry to 1; cout=1 then
//   means "no borrow". Without the macro the port does not exist and the
//   module only adds, with carry-in 0.
//
// Parameters:
//   WIDTH  operand and sum width in bits, legal range 2..32
//
// Ports:
//   clk    in   1      clock, all state updates on the rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      operation request, honoured in IDLE or DONE
//   sub    in   1      (SERIAL_ADDER_SUB_EN only) subtract select
//   a      in   WIDTH  operand A, captured with start
//   b      in   WIDTH  operand B, captured with start
//   busy   out  1      high while bits are being processed (RUN)
//   done   out  1      one-cycle pulse, sum/cout valid (DONE)
//   sum    out  WIDTH  result register, holds until the next start
//   cout   out  1      carry out of bit WIDTH-1, holds until the next start
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int CNT_W = $clog2(WIDTH);

    // Counter value on the edge that processes the MSB; the counter stops
    // here instead of incrementing, so it never wraps within an operation.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;

    // -----------------------------------------------------------------------
    // Operation select
    // -----------------------------------------------------------------------
    // Subtraction is a-b = a + ~b + 1: b is inverted on capture and the carry
    // flop is preset, so the datapath below is identical for both modes.
    logic sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // One-bit full adder on the operand LSBs
    // -----------------------------------------------------------------------
    logic bit_a;
    logic bit_b;
    logic bit_s;
    logic bit_c;

    assign bit_a = a_q[0];
    assign bit_b = b_q[0];
    assign bit_s = bit_a ^ bit_b ^ carry_q;
    assign bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Capture a new operation; from DONE this gives
                    // back-to-back operation with no IDLE cycle.
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end else if (state_q == DONE) begin
                    // Result registers simply hold on the way back to IDLE.
                    state_d = IDLE;
                end
            end

            RUN: begin
                // start is deliberately not looked at here: a request while
                // running must leave operands, counter and carry untouched.
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = bit_c;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    //
    // NOTE: the operand shift registers are reset along with the control
    // state; they are a handful of flops, not a memory array, and a clean
    // zero after reset is part of the visible behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // busy/done decode directly from the state register, so both clear with
    // the reset of state_q and never glitch relative to the FSM.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed self-checking bench for serial_adder at WIDTH=8. Inputs are driven
// 1 time unit after each rising edge and outputs are checked at that same
// point, i.e. they show the state produced by the edge just taken.
// Subtraction vectors are exercised only when SERIAL_ADDER_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int tests;
    int fails;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full operation with a single start pulse: 8 busy cycles, one done
    // cycle with the result, then IDLE with the result held.
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_sub, input logic [7:0] exp_sum, input logic exp_cout);
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " no done"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check({tag, " idle done"}, 32'(done), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " held sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " held cout"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        tick();
        tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Basic additions
        run_op("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("aa+55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        run_op("00+00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Start reasserted with new operands mid-run is ignored
        a     = 8'h0F;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < WIDTH; c++) begin
            if (c == 2) begin
                a     = 8'h33;
                b     = 8'h44;
                start = 1'b1;
            end else if (c == 3) begin
                start = 1'b0;
            end
            check("ignore busy", 32'(busy), 32'd1);
            tick();
        end
        start = 1'b0;
        check("ignore done", 32'(done), 32'd1);
        check("ignore sum", 32'(sum), 32'h10);
        check("ignore cout", 32'(cout), 32'd0);
        tick();
        check("ignore idle", 32'(done), 32'd0);

        // Reset mid-operation: ff+00 has shifted 0xF0 into sum after 4 bits
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("pre-rst sum", 32'(sum), 32'hF0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        for (int c = 0; c < 10; c++) begin
            check("midrst no done", 32'(done), 32'd0);
            tick();
        end

        // Start during reset is ignored
        a     = 8'h12;
        b     = 8'h34;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("rst start busy", 32'(busy), 32'd0);
        tick();
        check("rst start idle", 32'(busy), 32'd0);

        run_op("12+34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Start held high: one result every 9 cycles
        a     = 8'h80;
        b     = 8'h80;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < WIDTH; c++) begin
                check("b2b busy", 32'(busy), 32'd1);
                tick();
            end
            check("b2b done", 32'(done), 32'd1);
            case (k)
                0: begin
                    check("b2b sum0", 32'(sum), 32'h00);
                    check("b2b cout0", 32'(cout), 32'd1);
                    a = 8'h7F;
                    b = 8'h01;
                end
                1: begin
                    check("b2b sum1", 32'(sum), 32'h80);
                    check("b2b cout1", 32'(cout), 32'd0);
                    a = 8'h12;
                    b = 8'h34;
                end
                default: begin
                    check("b2b sum2", 32'(sum), 32'h46);
                    check("b2b cout2", 32'(cout), 32'd0);
                    a = 8'h00;
                    b = 8'h00;
                end
            endcase
            tick();
            check("b2b restart busy", 32'(busy), 32'd1);
            check("b2b restart done", 32'(done), 32'd0);
        end
        start = 1'b0;
        for (int c = 0; c < WIDTH; c++) tick();
        check("b2b tail done", 32'(done), 32'd1);
        check("b2b tail sum", 32'(sum), 32'h00);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op("07-05", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
        run_op("10-10", 8'h10, 8'h10, 1'b1, 8'h00, 1'b1);
        run_op("0f+01 after sub", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand and sum width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, which requests an operation and is sampled on the rising edge.
REQ-005 The module SHALL have ports a and b, input, WIDTH, the operands, captured on the edge that accepts start.
REQ-006 The module SHALL have port busy, output, 1, high while bits are being processed.
REQ-007 The module SHALL have port done, output, 1, a one-cycle pulse marking sum and cout valid.
REQ-008 The module SHALL have port sum, output, WIDTH, the result register.
REQ-009 The module SHALL have port cout, output, 1, the final carry out.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE, with busy=1 only in RUN and done=1 only in DONE.
REQ-011 Start SHALL be accepted in IDLE or DONE; on that edge a and b are loaded into shift registers, the carry flop is cleared, the bit counter is set to 0, sum is cleared, and the FSM enters RUN.
REQ-012 Start sampled in RUN SHALL be ignored, with no change to operands, counter or carry.
REQ-013 Each RUN edge SHALL process one bit LSB-first: s=a0^b0^c, c'=majority(a0,b0,c); s shifts into the MSB of sum, and the operands shift right.
REQ-014 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL not wrap during an operation; the FSM leaves RUN on the edge that processes bit WIDTH-1.
REQ-015 Latency: if start is accepted on edge E, done SHALL be high in the cycle after edge E+WIDTH, with sum equal to (a+b) mod 2^WIDTH and cout equal to the carry out of bit WIDTH-1.
REQ-016 From DONE, with no start, the FSM SHALL return to IDLE on the next edge; sum and cout SHALL hold until the next accepted start.
REQ-017 Start in DONE SHALL give back-to-back operation: done falls and RUN begins on the same edge.
REQ-018 Operand values SHALL not affect latency; the computation takes exactly WIDTH RUN cycles for any data.

Reset
REQ-019 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE and busy, done, sum, cout, the carry flop, the counter and the operand registers SHALL clear to 0.
REQ-020 Reset mid-operation SHALL abandon the operation with no done pulse; a start accepted after reset is released SHALL compute correctly.
REQ-021 Start SHALL be ignored during any edge at which rst_n=0.

Configuration
REQ-022 With macro SERIAL_ADDER_SUB_EN defined, the module SHALL add input port sub (1 bit), captured with start; sub=1 computes a-b by inverting b and presetting carry to 1, and cout=1 then means no borrow.
REQ-023 Without SERIAL_ADDER_SUB_EN, the sub port SHALL be absent and the module SHALL perform addition only, with carry-in 0.

Verification
REQ-024 WIDTH=8, a=0x0F, b=0x01, start pulse -> busy for 8 cycles, done for 1 cycle with sum=0x10 and cout=0, then IDLE with values held.
REQ-025 a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xAA, b=0x55 -> sum=0xFF, cout=0.
REQ-026 Start reasserted with a=0x33 at RUN cycle 3 of a 0x0F+0x01 operation -> ignored; result is still 0x10 on schedule.
REQ-027 rst_n low for one edge at RUN cycle 4 -> busy, done, sum and cout are 0 with no done pulse; then 0x12+0x34 -> sum=0x46.
REQ-028 Start held high continuously with new operands each DONE cycle -> one result per 9 cycles, each correct.
REQ-029 With SERIAL_ADDER_SUB_EN: 0x05-0x07 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1.
